// File: rtl/avl_timer.sv
// Avalon-MM 32-bit down-counting timer with prescaler, auto-reload and level interrupt.
// Register map by word: 0 CTRL {IE,AUTO,EN}, 1 LOAD, 2 COUNT, 3 STATUS {EXP}.
module avl_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] avl_address,
    input  logic        avl_read,
    input  logic        avl_write,
    input  logic [31:0] avl_writedata,
    input  logic [3:0]  avl_byteenable,
    output logic [31:0] avl_readdata,
    output logic        avl_waitrequest,
    output logic        avl_irq
);

    // state | meaning
    // IDLE  | waitrequest high, capture any request
    // ACK   | waitrequest low for one cycle, write commits on this edge
    typedef enum logic {S_IDLE, S_ACK} state_t;

    localparam logic [15:0] PC_LAST = 16'(PRESCALE - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_capture;
    logic        w_commit;

    logic [1:0]  r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_is_wr;

    logic [2:0]  r_ctrl;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_exp;
    logic [15:0] r_pc;

    logic [31:0] w_rd_mux;
    logic        w_tick;
    logic        w_expire;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_clr_exp;
    logic        w_unused_addr;

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    assign w_unused_addr = ^{avl_address[31:4], avl_address[1:0]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        avl_waitrequest = 1'b1;
        w_capture       = 1'b0;
        w_commit        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (avl_read || avl_write) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                avl_waitrequest = 1'b0;
                w_commit        = r_is_wr;
                w_state_nxt     = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = 32'h0;
        case (avl_address[3:2])
            2'd0: w_rd_mux = {29'h0, r_ctrl};
            2'd1: w_rd_mux = r_load;
            2'd2: w_rd_mux = r_count;
            2'd3: w_rd_mux = {31'h0, r_exp};
            default: w_rd_mux = 32'h0;
        endcase
    end

    // A simultaneous read+write request is treated as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= 2'd0;
            r_wdata      <= 32'h0;
            r_be         <= 4'h0;
            r_is_wr      <= 1'b0;
            avl_readdata <= 32'h0;
        end else if (w_capture) begin
            r_addr       <= avl_address[3:2];
            r_wdata      <= avl_writedata;
            r_be         <= avl_byteenable;
            r_is_wr      <= avl_write;
            avl_readdata <= w_rd_mux;
        end
    end

    assign w_tick     = r_ctrl[0] && (r_pc == PC_LAST);
    assign w_expire   = w_tick && (r_count == 32'd1);
    assign w_wr_ctrl  = w_commit && (r_addr == 2'd0) && r_be[0];
    assign w_wr_load  = w_commit && (r_addr == 2'd1);
    assign w_wr_count = w_commit && (r_addr == 2'd2) && (r_be != 4'h0);
    assign w_clr_exp  = w_commit && (r_addr == 2'd3) && r_be[0] && r_wdata[0];

    // Bus write to COUNT beats a tick; expiry beats a STATUS clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl  <= 3'h0;
            r_load  <= 32'h0;
            r_count <= 32'h0;
            r_exp   <= 1'b0;
            r_pc    <= 16'h0;
        end else begin
            if (!r_ctrl[0] || w_tick) r_pc <= 16'h0;
            else                      r_pc <= r_pc + 16'd1;

            if (w_wr_ctrl) r_ctrl <= r_wdata[2:0];
            if (w_wr_load) r_load <= f_merge(r_load, r_wdata, r_be);

            if (w_wr_count)
                r_count <= f_merge(r_count, r_wdata, r_be);
            else if (w_expire)
                r_count <= r_ctrl[1] ? r_load : 32'h0;
            else if (w_tick && (r_count != 32'h0))
                r_count <= r_count - 32'd1;

            if (w_expire)       r_exp <= 1'b1;
            else if (w_clr_exp) r_exp <= 1'b0;
        end
    end

    assign avl_irq = r_exp & r_ctrl[2];

endmodule
